// File: rtl/cmp_arb_pkg.sv
// Shared types for the signed compare arbiter.
// State encoding, operand width and the g/l/e result bundle.
package cmp_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_e;

  typedef struct packed {
    logic g;
    logic l;
    logic e;
  } cmp_res_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans ptr+1, ptr+2, ... modulo N and returns the first set bit.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/signed_cmp16.sv
// 16-bit two's complement magnitude comparator.
// Purely combinational; produces exactly one of g/l/e.
module signed_cmp16
  import cmp_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output cmp_res_t          res_o
);

  logic sign_diff;
  logic mag_gt;
  logic mag_eq;

  assign sign_diff = a_i[DATA_W-1] ^ b_i[DATA_W-1];
  assign mag_gt    = a_i[DATA_W-2:0] > b_i[DATA_W-2:0];
  assign mag_eq    = a_i[DATA_W-2:0] == b_i[DATA_W-2:0];

  // Differing signs: the non-negative operand wins.
  always_comb begin
    res_o.g = sign_diff ? ~a_i[DATA_W-1] : mag_gt;
    res_o.l = sign_diff ? a_i[DATA_W-1] : (~mag_gt & ~mag_eq);
    res_o.e = ~sign_diff & mag_eq;
  end

endmodule

// File: rtl/signed_cmp_arbiter.sv
// Round-robin arbiter sharing one registered signed comparator.
// Accept in IDLE, compare in EVAL, hold the result in RESP.
module signed_cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 16,
  parameter  int CNT_W   = 16,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      rsp_g,
  output logic                      rsp_l,
  output logic                      rsp_e,
  output logic [IW-1:0]             rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_cnt
);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  cmp_res_t          res_q, res_d;
  cmp_res_t          cmp_res;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .grant_o(gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  signed_cmp16 u_cmp (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .res_o(cmp_res)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          op_a_d    = req_a[gnt_idx*DATA_W +: DATA_W];
          op_b_d    = req_b[gnt_idx*DATA_W +: DATA_W];
          id_d      = gnt_idx;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        res_d   = cmp_res;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        // Only the owner's ready retires the response.
        if (rsp_ready[id_q]) begin
          ptr_d   = id_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_g    = res_q.g;
  assign rsp_l    = res_q.l;
  assign rsp_e    = res_q.e;
  assign rsp_id   = id_q;
  assign busy     = (state_q != IDLE);
  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_signed_cmp_arbiter.sv
// Self-checking bench for signed_cmp_arbiter.
// Directed scenarios plus random traffic against a transaction model.
module tb_signed_cmp_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic           rsp_g;
  logic           rsp_l;
  logic           rsp_e;
  logic [IW-1:0]  rsp_id;
  logic           busy;
  logic [15:0]    done_cnt;

  int checks   = 0;
  int failures = 0;

  signed_cmp_arbiter #(
    .NUM_REQ(N),
    .DATA_W (W),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_g    (rsp_g),
    .rsp_l    (rsp_l),
    .rsp_e    (rsp_e),
    .rsp_id   (rsp_id),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // {g, l, e} from plain signed arithmetic
  function automatic logic [2:0] ref_cmp(logic [15:0] a, logic [15:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return {sa > sb, sa < sb, sa == sb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle      = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < 10 && !idle; i++) begin
      @(negedge clk);
      #1;
      idle = !busy;
    end
    rsp_ready = '0;
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL drain: busy=%0b required 0", busy);
    end
  endtask

  task automatic run_txn(input int id, input logic [15:0] a,
                         input logic [15:0] b, output logic [2:0] res,
                         output int lat, output bit ok);
    bit seen;
    ok  = 1'b0;
    res = '0;
    lat = 0;
    @(negedge clk);
    req_valid[id]        = 1'b1;
    req_a[id*W +: W]     = a;
    req_b[id*W +: W]     = b;
    rsp_ready            = '0;
    #1;
    seen = req_ready[id];
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = req_ready[id];
    end
    if (!seen) return;
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    #1;
    for (int i = 0; i < 20 && !rsp_valid[id]; i++) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid[id]) return;
    res           = {rsp_g, rsp_l, rsp_e};
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready[id] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL reset_hs: ready=%b valid=%b required 0",
               req_ready, rsp_valid);
    end
    checks++;
    if ({rsp_g, rsp_l, rsp_e} !== 3'b000 || rsp_id !== '0) begin
      failures++;
      $display("FAIL reset_res: gle=%b id=%0d required 000/0",
               {rsp_g, rsp_l, rsp_e}, rsp_id);
    end
    checks++;
    if (busy !== 1'b0 || done_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stat: busy=%b cnt=%0d required 0/0",
               busy, done_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid    = 4'b0001;
    req_a[15:0]  = 16'hFFFF;
    req_b[15:0]  = 16'h0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_acc: ready=%b required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== '0 || req_ready !== '0) begin
      failures++;
      $display("FAIL single_eval: busy=%b valid=%b ready=%b required 1/0/0",
               busy, rsp_valid, req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || {rsp_g, rsp_l, rsp_e} !== 3'b010
        || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL single_rsp: valid=%b gle=%b id=%0d required 0001/010/0",
               rsp_valid, {rsp_g, rsp_l, rsp_e}, rsp_id);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (done_cnt !== 16'd1 || busy !== 1'b0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL single_done: cnt=%0d busy=%b valid=%b required 1/0/0",
               done_cnt, busy, rsp_valid);
    end
  endtask

  task automatic test_sign_boundary();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [2:0]  ve [4];
    logic [2:0]  res;
    int          lat;
    bit          ok;
    va = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
    vb = '{16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF};
    ve = '{3'b100, 3'b001, 3'b100, 3'b010};
    for (int i = 0; i < 4; i++) begin
      run_txn(i, va[i], vb[i], res, lat, ok);
      checks++;
      if (!ok || res !== ve[i] || lat != 2) begin
        failures++;
        $display("FAIL sign_%0d: ok=%0b gle=%b lat=%0d required 1/%b/2",
                 i, ok, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int          grants[$];
    logic [2:0]  exp_q[$];
    int          first;
    int          idx;
    logic [2:0]  e;
    do_reset();
    first     = -1;
    rsp_ready = '1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      req_valid = '1;
      for (int r = 0; r < N; r++) begin
        req_a[r*W +: W] = 16'($urandom);
        req_b[r*W +: W] = (($urandom % 4) == 0) ? req_a[r*W +: W]
                                                 : 16'($urandom);
      end
      #1;
      if (rsp_valid != '0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        checks++;
        if ({rsp_g, rsp_l, rsp_e} !== e) begin
          failures++;
          $display("FAIL rr_res: gle=%b required %b", {rsp_g, rsp_l, rsp_e}, e);
        end
      end
      if (first >= 0 && cyc == first + 18) begin
        checks++;
        if (done_cnt !== 16'd6) begin
          failures++;
          $display("FAIL rr_cnt: done_cnt=%0d required 6", done_cnt);
        end
        break;
      end
      if (req_ready != '0) begin
        idx = $clog2(int'(req_ready));
        grants.push_back(idx);
        exp_q.push_back(ref_cmp(req_a[idx*W +: W], req_b[idx*W +: W]));
        if (first < 0) first = cyc;
      end
    end
    checks++;
    if (grants.size() < 6 || grants[0] != 0 || grants[1] != 1
        || grants[2] != 2 || grants[3] != 3 || grants[4] != 0
        || grants[5] != 1) begin
      failures++;
      $display("FAIL rr_order: grants=%p required 0,1,2,3,0,1", grants);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [2:0] hold;
    logic [15:0] cnt0;
    bit ok;
    bit stable;
    drain();
    @(negedge clk);
    req_valid       = 4'b0100;
    req_a[2*W +: W] = 16'hFFFB;
    req_b[2*W +: W] = 16'h0003;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      ok = req_ready[2];
      @(negedge clk);
    end
    req_valid = '0;
    for (int i = 0; i < 10 && !rsp_valid[2]; i++) begin
      @(negedge clk);
      #1;
    end
    hold = {rsp_g, rsp_l, rsp_e};
    cnt0 = done_cnt;
    checks++;
    if (!ok || rsp_valid !== 4'b0100 || hold !== 3'b010) begin
      failures++;
      $display("FAIL bp_start: valid=%b gle=%b required 0100/010",
               rsp_valid, hold);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rsp_ready = 4'b0010;
      req_valid = 4'($urandom) & 4'b1011;
      #1;
      if (rsp_valid !== 4'b0100 || {rsp_g, rsp_l, rsp_e} !== hold
          || rsp_id !== 2'd2 || req_ready !== '0 || done_cnt !== cnt0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold: valid=%b gle=%b id=%0d ready=%b required 0100/%b/2/0",
               rsp_valid, {rsp_g, rsp_l, rsp_e}, rsp_id, req_ready, hold);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt !== cnt0 + 16'd1) begin
      failures++;
      $display("FAIL bp_release: busy=%b cnt=%0d required 0/%0d",
               busy, done_cnt, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    // abort in EVAL
    @(negedge clk);
    req_valid   = 4'b0001;
    req_a[15:0] = 16'h0005;
    req_b[15:0] = 16'h0002;
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1100;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || done_cnt !== 16'd0
        || req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rst_eval: valid=%b busy=%b cnt=%0d ready=%b required 0/0/0/0100",
               rsp_valid, busy, done_cnt, req_ready);
    end
    drain();
    // abort in RESP
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b1000) begin
      failures++;
      $display("FAIL rst_pre: valid=%b required 1000", rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || done_cnt !== 16'd0
        || req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rst_resp: valid=%b busy=%b cnt=%0d ready=%b required 0/0/0/0010",
               rsp_valid, busy, done_cnt, req_ready);
    end
    drain();
  endtask

  task automatic test_early_withdraw();
    bit granted1;
    drain();
    granted1 = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0001) begin
      failures++;
      $display("FAIL wd_rsp: valid=%b required 0001", rsp_valid);
    end
    req_valid = 4'b0010;
    #1;
    if (req_ready != '0) granted1 = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 4'b0001;
    #1;
    if (req_ready[1]) granted1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rsp_ready = '0;
      #1;
      if (req_ready != '0 || busy) granted1 = 1'b1;
    end
    checks++;
    if (granted1) begin
      failures++;
      $display("FAIL withdraw: req1 granted or fsm not idle (ready=%b busy=%b)",
               req_ready, busy);
    end
  endtask

  task automatic test_random();
    bit          m_has;
    int          m_id;
    int          m_age;
    int          m_last;
    int          m_cnt;
    logic [2:0]  m_out;
    logic [2:0]  m_new;
    int          pick;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_valid;
    int          bad;
    do_reset();
    m_has  = 1'b0;
    m_id   = 0;
    m_age  = 0;
    m_last = N - 1;
    m_cnt  = 0;
    m_out  = '0;
    m_new  = '0;
    bad    = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      req_valid = 4'($urandom) & 4'($urandom);
      rsp_ready = (($urandom % 10) < 6) ? 4'($urandom) | 4'b1111 : 4'($urandom);
      for (int r = 0; r < N; r++) begin
        req_a[r*W +: W] = 16'($urandom);
        req_b[r*W +: W] = (($urandom % 3) == 0) ? req_a[r*W +: W]
                                                 : 16'($urandom);
      end
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
      e_ready = (!m_has && pick >= 0) ? 4'(1 << pick) : '0;
      e_valid = (m_has && m_age >= 2) ? 4'(1 << m_id) : '0;
      #1;
      checks++;
      if (req_ready !== e_ready || rsp_valid !== e_valid
          || busy !== m_has || done_cnt !== 16'(m_cnt)
          || {rsp_g, rsp_l, rsp_e} !== m_out
          || (e_valid != '0 && rsp_id !== IW'(m_id))) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL rand_c%0d: ready=%b/%b valid=%b/%b busy=%b/%b cnt=%0d/%0d gle=%b/%b",
                   cyc, req_ready, e_ready, rsp_valid, e_valid, busy, m_has,
                   done_cnt, m_cnt, {rsp_g, rsp_l, rsp_e}, m_out);
      end
      if (!m_has) begin
        if (pick >= 0) begin
          m_has = 1'b1;
          m_id  = pick;
          m_age = 1;
          m_new = ref_cmp(req_a[pick*W +: W], req_b[pick*W +: W]);
        end
      end else if (m_age >= 2) begin
        if (rsp_ready[m_id]) begin
          m_has  = 1'b0;
          m_last = m_id;
          m_cnt++;
        end
      end else begin
        m_age++;
        m_out = m_new;
      end
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_sign_boundary();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_early_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
